// File: rtl/jtag_seq_engine.sv
// JTAG sequencing engine: pops bit-vector commands from a FWFT FIFO, shifts them out on
// TCK/TMS/TDI, pushes captured TDO bytes, and can record a sequence for repeated replay.
module jtag_seq_engine #(
  parameter int unsigned TCK_DIV   = 2,
  parameter int unsigned SEQ_DEPTH = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_seq_empty,
  input  logic [4:0] out_seq_command,
  input  logic [2:0] out_seq_bits,
  input  logic [7:0] out_seq_tms,
  input  logic [7:0] out_seq_tdi,
  input  logic [7:0] out_seq_read,
  output logic       out_seq_re,
  input  logic       in_seq_full,
  output logic       in_seq_we,
  output logic [7:0] in_seq_tdo,
  output logic       in_seq_flushed,
  output logic       TCK,
  output logic       TMS,
  output logic       TDI,
  input  logic       TDO
);

  localparam int unsigned AW = $clog2(SEQ_DEPTH);
  localparam logic [4:0] FIFO_CMD_WR      = 5'h01;
  localparam logic [4:0] FIFO_CMD_STORE   = 5'h02;
  localparam logic [4:0] FIFO_CMD_EXECUTE = 5'h03;
  localparam logic [4:0] FIFO_CMD_FLUSH   = 5'h04;
  localparam logic [7:0] DIV_M1  = 8'(TCK_DIV - 1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(SEQ_DEPTH);

  typedef enum logic [3:0] {
    IDLE, DECODE, SHIFT_LO, SHIFT_HI, PUSH, STORE_HDR, STORE_DATA, EXEC, FLUSH
  } state_t;

  state_t      state;
  logic [26:0] mem [SEQ_DEPTH];
  logic [26:0] ram_q;
  logic        mem_we;
  logic [AW:0] count;
  logic [AW:0] rd_ptr;
  logic [2:0]  e_bits;
  logic [7:0]  e_read;
  logic [7:0]  e_tdi;
  logic [7:0]  e_tms;
  logic [2:0]  bit_idx;
  logic [2:0]  next_idx;
  logic [7:0]  capture;
  logic [7:0]  cnt;
  logic [7:0]  push_mask;
  logic [3:0]  nbits;
  logic        last_bit;
  logic        exec_mode;
  logic        fetch;
  logic        in_store;

  always_comb begin
    nbits     = (e_bits == 3'd0) ? 4'd8 : {1'b0, e_bits};
    last_bit  = ({1'b0, bit_idx} == (nbits - 4'd1));
    next_idx  = bit_idx + 3'd1;
    push_mask = 8'((9'd1 << nbits) - 9'd1);
    mem_we    = (state == DECODE) && (out_seq_command == FIFO_CMD_STORE) &&
                in_store && (count < DEPTH_L);
  end

  // Sequence buffer: the stored count doubles as the saturating write pointer.
  always_ff @(posedge clk) begin
    if (mem_we) mem[count[AW-1:0]] <= {out_seq_bits, out_seq_read, out_seq_tdi, out_seq_tms};
    ram_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      TCK            <= 1'b0;
      TMS            <= 1'b1;
      TDI            <= 1'b0;
      out_seq_re     <= 1'b0;
      in_seq_we      <= 1'b0;
      in_seq_tdo     <= '0;
      in_seq_flushed <= 1'b0;
      count          <= '0;
      rd_ptr         <= '0;
      bit_idx        <= '0;
      capture        <= '0;
      cnt            <= '0;
      e_bits         <= '0;
      e_read         <= '0;
      e_tdi          <= '0;
      e_tms          <= '0;
      exec_mode      <= 1'b0;
      fetch          <= 1'b0;
      in_store       <= 1'b0;
    end else begin
      out_seq_re <= 1'b0;
      in_seq_we  <= 1'b0;
      case (state)
        // The pop strobe cycle still shows the old FIFO head, so it is never decoded twice.
        IDLE: if (!out_seq_empty && !out_seq_re) state <= DECODE;
        DECODE: begin
          out_seq_re <= 1'b1;
          in_store   <= (out_seq_command == FIFO_CMD_STORE);
          case (out_seq_command)
            FIFO_CMD_WR: begin
              e_bits         <= out_seq_bits;
              e_read         <= out_seq_read;
              e_tdi          <= out_seq_tdi;
              e_tms          <= out_seq_tms;
              TMS            <= out_seq_tms[0];
              TDI            <= out_seq_tdi[0];
              bit_idx        <= '0;
              cnt            <= '0;
              in_seq_flushed <= 1'b0;
              state          <= SHIFT_LO;
            end
            FIFO_CMD_STORE: begin
              if (!in_store) begin
                count <= '0;
                state <= STORE_HDR;
              end else begin
                if (count < DEPTH_L) count <= count + (AW+1)'(1);
                state <= STORE_DATA;
              end
            end
            FIFO_CMD_EXECUTE: begin
              rd_ptr         <= '0;
              fetch          <= 1'b0;
              exec_mode      <= 1'b1;
              in_seq_flushed <= 1'b0;
              state          <= EXEC;
            end
            FIFO_CMD_FLUSH: begin
              in_seq_flushed <= 1'b1;
              state          <= FLUSH;
            end
            default: state <= IDLE;
          endcase
        end
        STORE_HDR, STORE_DATA, FLUSH: state <= IDLE;
        EXEC: begin
          if (rd_ptr == count) begin
            exec_mode <= 1'b0;
            state     <= IDLE;
          end else if (!fetch) begin
            fetch <= 1'b1;
          end else begin
            fetch                          <= 1'b0;
            {e_bits, e_read, e_tdi, e_tms} <= ram_q;
            TMS                            <= ram_q[0];
            TDI                            <= ram_q[8];
            bit_idx                        <= '0;
            cnt                            <= '0;
            rd_ptr                         <= rd_ptr + (AW+1)'(1);
            state                          <= SHIFT_LO;
          end
        end
        // The pop cycle of a WR is not counted, giving one extra cycle of TMS/TDI setup.
        SHIFT_LO: if (!out_seq_re) begin
          if (cnt == DIV_M1) begin
            cnt   <= '0;
            TCK   <= 1'b1;
            state <= SHIFT_HI;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (cnt == 8'd0) capture[bit_idx] <= TDO;
          if (cnt == DIV_M1) begin
            cnt <= '0;
            TCK <= 1'b0;
            if (last_bit) begin
              if (e_read != 8'd0) state <= PUSH;
              else                state <= exec_mode ? EXEC : IDLE;
            end else begin
              bit_idx <= next_idx;
              TMS     <= e_tms[next_idx];
              TDI     <= e_tdi[next_idx];
              state   <= SHIFT_LO;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PUSH: if (!in_seq_full) begin
          in_seq_we  <= 1'b1;
          in_seq_tdo <= capture & e_read & push_mask;
          state      <= exec_mode ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_seq_engine.sv
// Self-checking bench for jtag_seq_engine: directed scenarios plus random WR traffic
// compared against a per-bit reference model of the JTAG sequence and result pushes.
module tb_jtag_seq_engine;

  localparam int unsigned DIV   = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [4:0] C_WR    = 5'h01;
  localparam logic [4:0] C_STORE = 5'h02;
  localparam logic [4:0] C_EXEC  = 5'h03;
  localparam logic [4:0] C_FLUSH = 5'h04;
  localparam logic [4:0] C_BAD   = 5'h1d;

  typedef struct packed {
    logic [4:0] code;
    logic [2:0] bits;
    logic [7:0] tms;
    logic [7:0] tdi;
    logic [7:0] rd;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_seq_empty = 1'b1;
  cmd_t       cur = '0;
  logic       out_seq_re;
  logic       in_seq_full = 1'b0;
  logic       in_seq_we;
  logic [7:0] in_seq_tdo;
  logic       in_seq_flushed;
  logic       TCK, TMS, TDI;
  logic       TDO = 1'b0;

  jtag_seq_engine #(.TCK_DIV(DIV), .SEQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .out_seq_empty(out_seq_empty), .out_seq_command(cur.code), .out_seq_bits(cur.bits),
    .out_seq_tms(cur.tms), .out_seq_tdi(cur.tdi), .out_seq_read(cur.rd),
    .out_seq_re(out_seq_re), .in_seq_full(in_seq_full), .in_seq_we(in_seq_we),
    .in_seq_tdo(in_seq_tdo), .in_seq_flushed(in_seq_flushed),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 clk = ~clk;

  // Command FIFO contents (stimulus side) and observations (monitor side).
  cmd_t       cmdq[$];
  logic       tdo_bits[$];
  logic [1:0] obs_pin[$];
  int         obs_rise_cyc[$];
  logic [7:0] obs_push[$];
  logic       obs_push_fl[$];
  int         rd_idx = 0, cyc = 0, last_act = 0, re_cyc = 0, pop_cnt = 0, obs_push_cyc = 0;
  logic       tck_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_seq_re) begin
      rd_idx   = rd_idx + 1;
      pop_cnt  = pop_cnt + 1;
      re_cyc   = cyc;
      last_act = cyc;
    end
    if (TCK && !tck_prev) begin
      obs_pin.push_back({TMS, TDI});
      obs_rise_cyc.push_back(cyc);
    end
    if (TCK != tck_prev) last_act = cyc;
    tck_prev = TCK;
    if (in_seq_we) begin
      obs_push.push_back(in_seq_tdo);
      obs_push_fl.push_back(in_seq_flushed);
      obs_push_cyc = cyc;
      last_act     = cyc;
    end
    if (!TCK) TDO = tdo_bits[obs_pin.size()];
    out_seq_empty = (rd_idx >= cmdq.size());
    cur           = out_seq_empty ? cmd_t'('0) : cmdq[rd_idx];
  end

  // Reference model state.
  logic [1:0] exp_pin[$];
  logic [7:0] exp_push[$];
  cmd_t       stored[$];
  int         n_checks = 0, n_pass = 0, n_fail = 0;
  int         pbase = 0, ubase = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [4:0] code, input logic [2:0] bits,
                     input logic [7:0] tms, input logic [7:0] tdi, input logic [7:0] rd);
    cmd_t c;
    c.code = code; c.bits = bits; c.tms = tms; c.tdi = tdi; c.rd = rd;
    cmdq.push_back(c);
  endtask

  // One entry shifted for 'cut' bits at most: pins per pulse, capture pushed if complete.
  task automatic model_entry(input cmd_t c, input int cut);
    int         n;
    logic [7:0] cap;
    n   = (c.bits == 3'd0) ? 8 : int'(c.bits);
    cap = '0;
    for (int i = 0; i < n && i < cut; i++) begin
      cap[i] = tdo_bits[exp_pin.size()];
      exp_pin.push_back({c.tms[i], c.tdi[i]});
    end
    if (cut >= n && c.rd != 8'd0) exp_push.push_back(cap & c.rd);
  endtask

  task automatic model_store(input cmd_t c);
    if (stored.size() < DEPTH) stored.push_back(c);
  endtask

  task automatic model_exec();
    foreach (stored[i]) model_entry(stored[i], 8);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); #1;
      if (rd_idx >= cmdq.size() && (cyc - last_act) > 12) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (obs_pin.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_rises"}, 32'(ok), 32'd1);
  endtask

  task automatic compare_step(input string tag);
    chk({tag, "_pulses"}, 32'(obs_pin.size()), 32'(exp_pin.size()));
    for (int k = pbase; k < exp_pin.size(); k++)
      chk($sformatf("%s_pin%0d", tag, k), 32'(obs_pin[k]), 32'(exp_pin[k]));
    chk({tag, "_pushes"}, 32'(obs_push.size()), 32'(exp_push.size()));
    for (int k = ubase; k < exp_push.size(); k++)
      chk($sformatf("%s_push%0d", tag, k), 32'(obs_push[k]), 32'(exp_push[k]));
    pbase = exp_pin.size();
    ubase = exp_push.size();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t       c;
    int         b, pc, rc, c0, p0, diff, bad;
    logic [1:0] pins0;

    for (int i = 0; i < 8192; i++) tdo_bits.push_back(1'($urandom));

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", 32'(TCK), 32'd0);
    chk("rst_tms", 32'(TMS), 32'd1);
    chk("rst_tdi", 32'(TDI), 32'd0);
    chk("rst_re", 32'(out_seq_re), 32'd0);
    chk("rst_we", 32'(in_seq_we), 32'd0);
    chk("rst_tdo", 32'(in_seq_tdo), 32'd0);
    chk("rst_flushed", 32'(in_seq_flushed), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Full byte WR with TDO held high
    for (int i = 0; i < 8; i++) tdo_bits[exp_pin.size() + i] = 1'b1;
    b = exp_pin.size();
    enq(C_WR, 3'd0, 8'h01, 8'hA5, 8'hFF);
    model_entry(cmdq[cmdq.size()-1], 8);
    wait_idle("wr8");
    compare_step("wr8");
    chk("wr8_push_ff", 32'(obs_push[obs_push.size()-1]), 32'hFF);
    chk("wr8_latency", 32'(obs_rise_cyc[b] - re_cyc), 32'(DIV + 1));
    diff = 0;
    for (int k = b; k < b + 7; k++) if (obs_rise_cyc[k+1] - obs_rise_cyc[k] != 2 * DIV) diff++;
    chk("wr8_period", 32'(diff), 32'd0);

    // Short WR, 3 bits with TDO 1,0,1
    b = exp_pin.size();
    tdo_bits[b] = 1'b1; tdo_bits[b+1] = 1'b0; tdo_bits[b+2] = 1'b1;
    enq(C_WR, 3'd3, 8'($urandom), 8'($urandom), 8'h05);
    model_entry(cmdq[cmdq.size()-1], 8);
    wait_idle("wr3");
    compare_step("wr3");
    chk("wr3_push_05", 32'(obs_push[obs_push.size()-1]), 32'h05);

    // Random WR traffic with one unknown command in the stream
    p0 = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        enq(C_BAD, 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        enq(C_WR, 3'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
        model_entry(cmdq[cmdq.size()-1], 8);
      end
    end
    wait_idle("rnd");
    compare_step("rnd");
    chk("rnd_pops", 32'(pop_cnt - p0), 32'd20);
    chk("rnd_flushed", 32'(in_seq_flushed), 32'd0);

    // STORE header L=20, three entries of 8+8+4 bits; no pin motion while storing
    pins0 = {TMS, TDI};
    p0 = pop_cnt;
    stored.delete();
    enq(C_STORE, 3'd0, 8'd20, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      enq(C_STORE, (i == 2) ? 3'd4 : 3'd0, 8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)));
      model_store(cmdq[cmdq.size()-1]);
    end
    wait_idle("store");
    chk("store_no_tck", 32'(obs_pin.size()), 32'(exp_pin.size()));
    chk("store_pins_held", 32'({TMS, TDI}), 32'(pins0));
    chk("store_pops", 32'(pop_cnt - p0), 32'd4);

    // Two replays then FLUSH
    b = exp_pin.size();
    enq(C_EXEC, 3'd0, 8'd0, 8'd0, 8'd0);
    model_exec();
    enq(C_EXEC, 3'd0, 8'd0, 8'd0, 8'd0);
    model_exec();
    enq(C_FLUSH, 3'd0, 8'd0, 8'd0, 8'd0);
    pc = ubase;
    wait_idle("exec2");
    compare_step("exec2");
    chk("exec2_len", 32'(obs_pin.size() - b), 32'd40);
    diff = 0;
    for (int k = b; k < b + 20 && k + 20 < obs_pin.size(); k++)
      if (obs_pin[k] !== obs_pin[k+20]) diff++;
    chk("exec2_replay_same", 32'(diff), 32'd0);
    bad = 0;
    for (int k = pc; k < obs_push_fl.size(); k++) if (obs_push_fl[k] !== 1'b0) bad++;
    chk("exec2_flushed_at_push", 32'(bad), 32'd0);
    chk("exec2_flushed_final", 32'(in_seq_flushed), 32'd1);

    // Result FIFO full for 50 clk at PUSH
    in_seq_full = 1'b1;
    b = exp_pin.size();
    enq(C_WR, 3'd0, 8'($urandom), 8'($urandom), 8'hFF);
    model_entry(cmdq[cmdq.size()-1], 8);
    wait_rises("stall", b + 8);
    repeat (3) @(negedge clk);
    #1;
    rc = obs_pin.size();
    pc = obs_push.size();
    repeat (50) @(negedge clk);
    #1;
    chk("stall_no_tck", 32'(obs_pin.size()), 32'(rc));
    chk("stall_no_push", 32'(obs_push.size()), 32'(pc));
    chk("stall_tck_low", 32'(TCK), 32'd0);
    c0 = cyc;
    in_seq_full = 1'b0;
    for (int i = 0; i < 20 && obs_push.size() == pc; i++) begin
      @(negedge clk); #1;
    end
    chk("stall_release_lat", 32'(obs_push_cyc - c0), 32'd1);
    wait_idle("stall");
    compare_step("stall");
    chk("stall_flushed", 32'(in_seq_flushed), 32'd0);

    // Reset during bit 4 of a WR, then EXECUTE must be a no-op
    b = exp_pin.size();
    enq(C_WR, 3'd0, 8'($urandom), 8'($urandom), 8'hFF);
    model_entry(cmdq[cmdq.size()-1], 5);
    pc = obs_push.size();
    wait_rises("abort", b + 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tck", 32'(TCK), 32'd0);
    chk("abort_tms", 32'(TMS), 32'd1);
    chk("abort_re", 32'(out_seq_re), 32'd0);
    chk("abort_we", 32'(in_seq_we), 32'd0);
    chk("abort_tdo", 32'(in_seq_tdo), 32'd0);
    rst = 1'b0;
    stored.delete();
    wait_idle("abort");
    chk("abort_no_push", 32'(obs_push.size()), 32'(pc));
    enq(C_EXEC, 3'd0, 8'd0, 8'd0, 8'd0);
    model_exec();
    wait_idle("abort_exec");
    compare_step("abort");

    // Six STORE entries into a 4-deep buffer, then replay
    p0 = pop_cnt;
    stored.delete();
    enq(C_STORE, 3'd0, 8'd48, 8'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      enq(C_STORE, 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)));
      model_store(cmdq[cmdq.size()-1]);
    end
    enq(C_EXEC, 3'd0, 8'd0, 8'd0, 8'd0);
    b = obs_push.size();
    model_exec();
    wait_idle("depth");
    compare_step("depth");
    chk("depth_pops", 32'(pop_cnt - p0), 32'd8);
    chk("depth_replayed", 32'(obs_push.size() - b), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
